// File: rtl/spram_be_init.sv
// Single-port byte-enable RAM with a clear engine that fills the array with
// INIT_VAL after reset; read data is registered with 1 or 2 cycles of latency.
module spram_be_init #(
    parameter int          DWIDTH     = 32,
    parameter int          AWIDTH     = 10,
    parameter int          RD_LAT     = 1,
    parameter logic [31:0] INIT_VAL   = 32'h1234_7f7f,
    parameter bit          CLR_ON_RST = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [AWIDTH-1:0]   addr,
    input  logic                cen,
    input  logic                wen,
    input  logic [DWIDTH/8-1:0] ben,
    input  logic [DWIDTH-1:0]   din,
    output logic [DWIDTH-1:0]   dout,
    output logic                dvalid,
    output logic                busy
);
    localparam int                NB     = DWIDTH / 8;
    localparam int                DEPTH  = 2 ** AWIDTH;
    localparam logic [DWIDTH-1:0] INIT_W = DWIDTH'(INIT_VAL);

    if (DWIDTH < 8 || DWIDTH % 8 != 0) begin : g_bad_dwidth
        $error("spram_be_init: DWIDTH must be a positive multiple of 8");
    end
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
        $error("spram_be_init: RD_LAT must be 1 or 2");
    end

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [AWIDTH-1:0] clr_addr;
    // Power-up contents come from the declaration initialiser, independent of rst.
    logic [DWIDTH-1:0] mem [DEPTH] = '{default: INIT_W};
    logic [AWIDTH-1:0] wr_addr;
    logic [DWIDTH-1:0] wr_data;
    logic [NB-1:0]     wr_be;
    logic              rd_req;

    assign busy = rst ? CLR_ON_RST : (state == CLEAR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLR_ON_RST ? CLEAR : IDLE;
            clr_addr <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == CLEAR && (&clr_addr)) state_nxt = IDLE;
    end

    // Clear engine owns the single port while CLEAR; user requests are dropped.
    always_comb begin
        wr_addr = addr;
        wr_data = din;
        wr_be   = '0;
        if (!rst) begin
            if (state == CLEAR) begin
                wr_addr = clr_addr;
                wr_data = INIT_W;
                wr_be   = '1;
            end else if (!cen && !wen) begin
                wr_be = ben;
            end
        end
    end

    assign rd_req = !rst && (state == IDLE) && !cen && wen;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
    end

    if (RD_LAT == 2) begin : g_rd_lat2
        logic [DWIDTH-1:0] rd_data_p0;
        logic              vld_p0;

        always_ff @(posedge clk) begin
            if (rst) begin
                rd_data_p0 <= '0;
                vld_p0     <= 1'b0;
                dout       <= '0;
                dvalid     <= 1'b0;
            end else begin
                // p0: array read
                vld_p0 <= rd_req;
                if (rd_req) rd_data_p0 <= mem[addr];
                // p1: output register
                dvalid <= vld_p0;
                if (vld_p0) dout <= rd_data_p0;
            end
        end
    end else begin : g_rd_lat1
        always_ff @(posedge clk) begin
            if (rst) begin
                dout   <= '0;
                dvalid <= 1'b0;
            end else begin
                // p0: array read straight into the output register
                dvalid <= rd_req;
                if (rd_req) dout <= mem[addr];
            end
        end
    end
endmodule

// File: doc/spram_be_init.md
SPRAM_BE_INIT -- requirements
Module: spram_be_init

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 32, data word width in bits; legal values are multiples of 8, and any other value SHALL be an elaboration error.
REQ-002 The block SHALL have parameter AWIDTH, default 10, address width; depth = 2**AWIDTH words.
REQ-003 The block SHALL have parameter RD_LAT, default 1, read latency in cycles; legal values are 1 and 2, and any other value SHALL be an elaboration error.
REQ-004 The block SHALL have parameter INIT_VAL, default 32'h1234_7f7f, clear pattern, truncated or zero-extended to DWIDTH.
REQ-005 The block SHALL have parameter CLR_ON_RST, default 1; 1 = hardware clear after reset, 0 = no clear.
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-008 The block SHALL have port addr, input, AWIDTH bits, word address.
REQ-009 The block SHALL have port cen, input, 1 bit, active-low chip enable.
REQ-010 The block SHALL have port wen, input, 1 bit; 0 = write, 1 = read; valid only when cen=0.
REQ-011 The block SHALL have port ben, input, DWIDTH/8 bits, active-high byte write enables; ben[i] covers din[8i+7:8i].
REQ-012 The block SHALL have port din, input, DWIDTH bits, write data.
REQ-013 The block SHALL have port dout, output, DWIDTH bits, registered read data.
REQ-014 The block SHALL have port dvalid, output, 1 bit, one-cycle pulse marking new dout.
REQ-015 The block SHALL have port busy, output, 1 bit; high while the clear engine owns the array.

Function
REQ-016 The storage SHALL be a single-port array of 2**AWIDTH x DWIDTH inferred as block RAM; it SHALL hold one access per cycle.
REQ-017 A write SHALL occur when cen=0, wen=0, busy=0, updating only the bytes with ben[i]=1 at mem[addr] on that edge; ben all-zero SHALL leave memory unchanged.
REQ-018 A read SHALL occur when cen=0, wen=1, busy=0.
REQ-019 When RD_LAT=1, dout SHALL equal mem[addr] and dvalid SHALL be 1 for one cycle at the first edge after the request.
REQ-020 When RD_LAT=2, the block SHALL add an output register stage, and dout/dvalid SHALL appear at the second edge after the request.
REQ-021 Back-to-back reads SHALL be accepted every cycle with one dvalid per read, in order.
REQ-022 When no read completes, dout SHALL hold its last value and dvalid SHALL be 0.
REQ-023 A write SHALL never produce dvalid, and write data SHALL be visible to a read issued on the next cycle.
REQ-024 The clear engine FSM SHALL have two states, IDLE and CLEAR, plus a clr_addr counter of AWIDTH bits.
REQ-025 In CLEAR, the engine SHALL write INIT_VAL (all bytes) to mem[clr_addr] each cycle and increment clr_addr.
REQ-026 When the write to address 2**AWIDTH-1 completes, the FSM SHALL go to IDLE, and busy SHALL be 0 from the next cycle.
REQ-027 busy SHALL be 1 exactly while the state is CLEAR: 2**AWIDTH cycles after rst deasserts.
REQ-028 User requests while busy=1 SHALL be dropped silently: no write, no read, no dvalid, with no queuing.
REQ-029 When CLR_ON_RST=0, the FSM SHALL remain in IDLE, busy SHALL stay 0, and memory contents SHALL be unchanged by reset.

Reset
REQ-030 While rst=1, the block SHALL set state to CLEAR (CLR_ON_RST=1) or IDLE (CLR_ON_RST=0), and clear clr_addr, dout, dvalid and the RD_LAT=2 pipeline stage to 0.
REQ-031 While rst=1, busy SHALL be CLR_ON_RST.
REQ-032 While rst=1, no array write SHALL occur, and any in-flight read SHALL be discarded with no dvalid.
REQ-033 rst asserted mid-clear SHALL restart the clear from address 0 after deassertion, giving a full 2**AWIDTH busy cycles.
REQ-034 Memory SHALL also be initialised to INIT_VAL at configuration (power-up), independent of rst.

Verification (AWIDTH=4, DWIDTH=32, default INIT_VAL)
REQ-035 Bench scenario: rst high 2 cycles then low -> busy=1 for exactly 16 cycles then 0; dout=0 and dvalid=0 throughout.
REQ-036 Bench scenario: after clear, read addr 5 with RD_LAT=1 -> dout=0x12347F7F and a one-cycle dvalid at the next edge; with RD_LAT=2 -> the same at the second edge.
REQ-037 Bench scenario: write addr 3, din=0xAABBCCDD, ben=4'b0101, then read addr 3 -> dout=0x12BB7FDD.
REQ-038 Bench scenario: reads to addr 0,1,2 on consecutive cycles after writing 0x11,0x22,0x33 with ben=4'hF -> dvalid high 3 consecutive cycles, dout 0x11,0x22,0x33 in order.
REQ-039 Bench scenario: write addr 7 with 0xDEADBEEF while busy=1, then read addr 7 after busy falls -> dout=0x12347F7F, with no dvalid during busy.
REQ-040 Bench scenario: rst pulsed at clear cycle 8 -> busy stays high for 16 cycles after the second deassertion, and all 16 words read back as 0x12347F7F.
